// File: rtl/led_pattern_driver.sv
// LED bring-up indicator: tick prescaler, PWM generator and OFF/ON/BLINK/BREATHE patterns.
// Defining LED_ACTIVITY_EN adds an activity-flash overlay that inverts the pattern.
module led_pattern_driver #(
  parameter int TICK_DIV      = 46875,
  parameter int PWM_BITS      = 8,
  parameter int BLINK_TICKS   = 128,
  parameter int STRETCH_TICKS = 8
) (
  input  logic       clk_12mhz,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       activity,
  output logic       led,
  output logic       tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [BLK_W-1:0]    BLK_LAST  = BLK_W'(BLINK_TICKS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
  localparam logic [PWM_BITS-1:0] DUTY_PRE  = DUTY_MAX - PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic {
    BR_UP   = 1'b0,
    BR_DOWN = 1'b1
  } breathe_e;

  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    div_d;
  logic                tick_q;
  logic [PWM_BITS-1:0] pwm_q;
  mode_e               mode_q;
  logic                restart;
  logic [BLK_W-1:0]    blink_cnt_q;
  logic                blink_phase_q;
  breathe_e            br_state_q;
  logic [PWM_BITS-1:0] duty_q;
  logic                pwm_out;
  logic                flash;
  logic                pat;
  logic                led_q;

  assign div_d   = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
  assign restart = (mode != mode_q);
  assign pwm_out = (pwm_q < duty_q);

  // tick_q is precomputed from div_d so it is high exactly while div_q == TICK_DIV-1
  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      pwm_q  <= '0;
      mode_q <= MODE_OFF;
    end else begin
      div_q  <= div_d;
      tick_q <= (div_d == DIV_LAST);
      pwm_q  <= pwm_q + PWM_BITS'(1);
      mode_q <= mode_e'(mode);
    end
  end

  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else if (restart) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else if (tick_q) begin
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BLK_W'(1);
      end
    end
  end

  // Breathe ramp turns around on reaching an end value, so duty never wraps.
  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      br_state_q <= BR_UP;
      duty_q     <= '0;
    end else if (restart) begin
      br_state_q <= BR_UP;
      duty_q     <= '0;
    end else if (tick_q) begin
      case (br_state_q)
        BR_UP: begin
          if (duty_q != DUTY_MAX) begin
            duty_q <= duty_q + PWM_BITS'(1);
            if (duty_q == DUTY_PRE) br_state_q <= BR_DOWN;
          end else begin
            br_state_q <= BR_DOWN;
          end
        end
        default: begin
          if (duty_q != '0) begin
            duty_q <= duty_q - PWM_BITS'(1);
            if (duty_q == DUTY_ONE) br_state_q <= BR_UP;
          end else begin
            br_state_q <= BR_UP;
          end
        end
      endcase
    end
  end

`ifdef LED_ACTIVITY_EN
  localparam int STR_W = (STRETCH_TICKS > 0) ? $clog2(STRETCH_TICKS + 1) : 1;
  localparam logic [STR_W-1:0] STR_LOAD = STR_W'(STRETCH_TICKS);

  logic [STR_W-1:0] stretch_cnt_q;

  // A fresh activity strobe reloads the stretch even when a tick lands in the same cycle.
  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      stretch_cnt_q <= '0;
    end else if (activity) begin
      stretch_cnt_q <= STR_LOAD;
    end else if (tick_q && (stretch_cnt_q != '0)) begin
      stretch_cnt_q <= stretch_cnt_q - STR_W'(1);
    end
  end

  assign flash = (stretch_cnt_q != '0);
`else
  logic unused_activity;
  assign unused_activity = activity;
  assign flash           = 1'b0;
`endif

  always_comb begin
    pat = 1'b0;
    case (mode_q)
      MODE_OFF:     pat = 1'b0;
      MODE_ON:      pat = 1'b1;
      MODE_BLINK:   pat = blink_phase_q;
      MODE_BREATHE: pat = pwm_out;
      default:      pat = 1'b0;
    endcase
  end

  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= 1'b0;
    end else begin
      led_q <= pat ^ flash;
    end
  end

  assign led  = led_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Randomised self-checking bench for led_pattern_driver against a tick-count reference model.
// Follows LED_ACTIVITY_EN so the same bench suits both builds.
module tb_led_pattern_driver;

  localparam int TD   = 4;
  localparam int PB   = 3;
  localparam int BT   = 2;
  localparam int ST   = 3;
  localparam int DMAX = (1 << PB) - 1;
  localparam int PWIN = 1 << PB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] mode = 2'd0;
  logic       activity = 1'b0;
  logic       led;
  logic       tick;

  int total = 0;
  int bad   = 0;

  // Reference model: cycle index since reset, mode as seen one cycle late,
  // ticks since last pattern restart and ticks since last activity strobe.
  int cyc;
  int mq;
  int nt;
  int ta;
  bit act_seen;
  bit exp_led;
  bit exp_tick;

  always #5 clk = ~clk;

  led_pattern_driver #(
    .TICK_DIV      (TD),
    .PWM_BITS      (PB),
    .BLINK_TICKS   (BT),
    .STRETCH_TICKS (ST)
  ) dut (
    .clk_12mhz (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .activity  (activity),
    .led       (led),
    .tick      (tick)
  );

  function automatic int tri_duty(input int n);
    int m;
    m = n % (2 * DMAX);
    return (m <= DMAX) ? m : (2 * DMAX - m);
  endfunction

  function automatic bit model_pat();
    case (mq)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ((nt / BT) % 2) == 0;
      default: return (cyc % PWIN) < tri_duty(nt);
    endcase
  endfunction

  function automatic bit model_flash();
`ifdef LED_ACTIVITY_EN
    return act_seen && (ta < ST);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    cyc = 0; mq = 0; nt = 0; ta = 0; act_seen = 1'b0;
    exp_led = 1'b0; exp_tick = 1'b0;
  endtask

  // Advance model and DUT by one cycle; leaves the bench at the following negedge.
  task automatic step();
    bit t;
    t = ((cyc % TD) == TD - 1);
    exp_led = model_pat() ^ model_flash();
    if (int'(mode) != mq) begin
      mq = int'(mode);
      nt = 0;
    end else if (t) begin
      nt++;
    end
    if (activity) begin
      act_seen = 1'b1;
      ta = 0;
    end else if (t) begin
      ta++;
    end
    cyc++;
    exp_tick = ((cyc % TD) == TD - 1);
    @(posedge clk);
    @(negedge clk);
    activity = 1'b0;
  endtask

  task automatic apply_reset();
    activity = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    mode = 2'd0;
    #2 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (led !== 1'b0) begin bad++; $display("FAIL reset_led got=%b want=0", led); end
      total++;
      if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", tick); end
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_off();
    mode = 2'd0;
    repeat (40) begin
      step();
      total++;
      if (led !== 1'b0) begin bad++; $display("FAIL off_led cyc=%0d got=%b want=0", cyc, led); end
      total++;
      if (tick !== exp_tick) begin bad++; $display("FAIL off_tick cyc=%0d got=%b want=%b", cyc, tick, exp_tick); end
    end
  endtask

  task automatic test_on();
    apply_reset();
    mode = 2'd0;
    while (cyc < 20) begin
      if (cyc == 10) mode = 2'd1;
      step();
      total++;
      if (led !== exp_led) begin bad++; $display("FAIL on_model cyc=%0d got=%b want=%b", cyc, led, exp_led); end
      total++;
      if (led !== (cyc >= 12)) begin bad++; $display("FAIL on_timing cyc=%0d got=%b want=%b", cyc, led, (cyc >= 12)); end
    end
  endtask

  task automatic test_blink();
    int highs;
    apply_reset();
    mode = 2'd2;
    repeat (8) begin
      step();
      total++;
      if (led !== exp_led) begin bad++; $display("FAIL blink_model cyc=%0d got=%b want=%b", cyc, led, exp_led); end
    end
    highs = 0;
    repeat (32) begin
      step();
      if (led === 1'b1) highs++;
      total++;
      if (led !== exp_led) begin bad++; $display("FAIL blink_model cyc=%0d got=%b want=%b", cyc, led, exp_led); end
    end
    total++;
    if (highs != 16) begin bad++; $display("FAIL blink_duty got=%0d want=16", highs); end
  endtask

  task automatic test_breathe();
    apply_reset();
    mode = 2'd3;
    repeat (2 * 2 * DMAX * TD + 20) begin
      step();
      total++;
      if (led !== exp_led) begin bad++; $display("FAIL breathe_model cyc=%0d got=%b want=%b", cyc, led, exp_led); end
      if (cyc >= 2 && ((cyc - 1) % PWIN) == PWIN - 1) begin
        total++;
        if (led !== 1'b0) begin bad++; $display("FAIL breathe_max cyc=%0d got=%b want=0", cyc, led); end
      end
    end
  endtask

  task automatic test_activity();
    bit want_first;
    apply_reset();
    mode = 2'd0;
    repeat (2) step();
    activity = 1'b1;
    step();
    step();
`ifdef LED_ACTIVITY_EN
    want_first = 1'b1;
`else
    want_first = 1'b0;
`endif
    total++;
    if (led !== want_first) begin bad++; $display("FAIL act_first got=%b want=%b", led, want_first); end
    repeat (2 * TD - 2) begin
      step();
      total++;
      if (led !== exp_led) begin bad++; $display("FAIL act_model cyc=%0d got=%b want=%b", cyc, led, exp_led); end
    end
    activity = 1'b1;
    repeat (6 * TD) begin
      step();
      total++;
      if (led !== exp_led) begin bad++; $display("FAIL act_retrig cyc=%0d got=%b want=%b", cyc, led, exp_led); end
    end
    total++;
    if (led !== 1'b0) begin bad++; $display("FAIL act_expire got=%b want=0", led); end
  endtask

  task automatic test_random();
    apply_reset();
    repeat (800) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      activity = ($urandom_range(0, 14) == 0);
      step();
      total++;
      if (led !== exp_led) begin bad++; $display("FAIL rand_led cyc=%0d mode=%0d got=%b want=%b", cyc, mq, led, exp_led); end
      total++;
      if (tick !== exp_tick) begin bad++; $display("FAIL rand_tick cyc=%0d got=%b want=%b", cyc, tick, exp_tick); end
    end
  endtask

  task automatic test_reset_mid();
    int budget;
    apply_reset();
    mode = 2'd3;
    budget = 200;
    while (!(mq == 3 && tri_duty(nt) == 5) && budget > 0) begin
      step();
      budget--;
    end
    total++;
    if (budget == 0) begin bad++; $display("FAIL mid_reach got=timeout want=duty5"); end
    rst_n = 1'b0;
    #1;
    total++;
    if (led !== 1'b0) begin bad++; $display("FAIL mid_led_async got=%b want=0", led); end
    total++;
    if (tick !== 1'b0) begin bad++; $display("FAIL mid_tick_async got=%b want=0", tick); end
    repeat (2) begin
      @(negedge clk);
      total++;
      if (led !== 1'b0) begin bad++; $display("FAIL mid_led_held got=%b want=0", led); end
    end
    rst_n = 1'b1;
    model_reset();
    repeat (40) begin
      step();
      total++;
      if (led !== exp_led) begin bad++; $display("FAIL mid_model cyc=%0d got=%b want=%b", cyc, led, exp_led); end
      if (cyc <= 9) begin
        total++;
        if (led !== (cyc == 9)) begin bad++; $display("FAIL mid_restart cyc=%0d got=%b want=%b", cyc, led, (cyc == 9)); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_off();
    test_on();
    test_blink();
    test_breathe();
    test_activity();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
